// File: rtl/mii_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : mii_tx_framer
// Brief    : AXI-stream byte frames to MII TX nibbles with preamble/SFD,
//            minimum-size padding, CRC32 FCS and inter-frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module mii_tx_framer #(
    parameter int ENABLE_PADDING   = 1,
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int IFG_BYTES        = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [3:0] mii_txd,
    output logic       mii_tx_en,
    output logic       mii_tx_er,
    output logic       start_packet,
    output logic       error_underflow
);

    localparam int c_IFG_CYCLES = IFG_BYTES * 2;
    localparam int c_CNT_MAX    = (c_IFG_CYCLES > 15) ? c_IFG_CYCLES : 15;
    localparam int c_CNT_W      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_PRE_LAST    = c_CNT_W'(14);
    localparam logic [c_CNT_W-1:0] c_FCS_LAST    = c_CNT_W'(7);
    localparam logic [c_CNT_W-1:0] c_IFG_LAST    = c_CNT_W'(c_IFG_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [15:0]        c_MIN_PAYLOAD = 16'(MIN_FRAME_LENGTH - 4);
    localparam logic [31:0]        c_CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]        c_CRC_POLY    = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        c_S_IDLE     = 3'd0,
        c_S_PREAMBLE = 3'd1,
        c_S_SFD      = 3'd2,
        c_S_PAYLOAD  = 3'd3,
        c_S_PAD      = 3'd4,
        c_S_FCS      = 3'd5,
        c_S_IFG      = 3'd6,
        c_S_DROP     = 3'd7
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_phase;     // 0: low nibble on the wire, 1: high nibble
    logic [7:0]           r_data;
    logic                 r_last;
    logic                 r_user;
    logic [15:0]          r_byte_cnt;
    logic [31:0]          r_crc;
    logic [31:0]          r_fcs_sr;

    logic [31:0]          w_fcs;
    logic                 w_pad_needed;
    logic [15:0]          w_byte_cnt_inc;

    function automatic logic [31:0] crc_nibble(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ nib[i]) c = (c >> 1) ^ c_CRC_POLY;
            else               c = c >> 1;
        end
        return c;
    endfunction

    // A frame flagged bad with tlast gets the raw register so the receiver's check fails.
    assign w_fcs          = r_user ? r_crc : ~r_crc;
    assign w_pad_needed   = (ENABLE_PADDING != 0) && (r_byte_cnt < c_MIN_PAYLOAD);
    assign w_byte_cnt_inc = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_S_IDLE;
            r_cnt           <= '0;
            r_phase         <= 1'b0;
            r_data          <= 8'h00;
            r_last          <= 1'b0;
            r_user          <= 1'b0;
            r_byte_cnt      <= 16'h0000;
            r_crc           <= c_CRC_INIT;
            r_fcs_sr        <= 32'h0000_0000;
            mii_txd         <= 4'h0;
            mii_tx_en       <= 1'b0;
            mii_tx_er       <= 1'b0;
            s_axis_tready   <= 1'b0;
            start_packet    <= 1'b0;
            error_underflow <= 1'b0;
        end else begin
            start_packet    <= 1'b0;
            error_underflow <= 1'b0;
            mii_tx_er       <= 1'b0;
            s_axis_tready   <= 1'b0;

            case (r_state)
                // The last IFG cycle doubles as IDLE so a waiting frame keeps the gap exact.
                c_S_IDLE, c_S_IFG: begin
                    mii_tx_en <= 1'b0;
                    mii_txd   <= 4'h0;
                    r_crc     <= c_CRC_INIT;
                    if (r_state == c_S_IFG && r_cnt != c_IFG_LAST) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end else if (s_axis_tvalid) begin
                        r_state   <= c_S_PREAMBLE;
                        r_cnt     <= '0;
                        mii_tx_en <= 1'b1;
                        mii_txd   <= 4'h5;
                    end else begin
                        r_state <= c_S_IDLE;
                    end
                end

                c_S_PREAMBLE: begin
                    if (r_cnt == c_PRE_LAST) begin
                        r_state       <= c_S_SFD;
                        mii_txd       <= 4'hD;
                        start_packet  <= 1'b1;
                        s_axis_tready <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + c_CNT_ONE;
                        mii_txd <= 4'h5;
                    end
                end

                c_S_SFD, c_S_PAYLOAD: begin
                    if (r_state == c_S_PAYLOAD && !r_phase) begin
                        mii_txd       <= r_data[7:4];
                        r_crc         <= crc_nibble(r_crc, r_data[7:4]);
                        r_phase       <= 1'b1;
                        s_axis_tready <= !r_last;
                    end else if (r_state == c_S_PAYLOAD && r_last) begin
                        r_phase <= 1'b0;
                        if (w_pad_needed) begin
                            r_state    <= c_S_PAD;
                            mii_txd    <= 4'h0;
                            r_crc      <= crc_nibble(r_crc, 4'h0);
                            r_byte_cnt <= w_byte_cnt_inc;
                        end else begin
                            r_state  <= c_S_FCS;
                            r_cnt    <= '0;
                            mii_txd  <= w_fcs[3:0];
                            r_fcs_sr <= w_fcs >> 4;
                        end
                    end else if (s_axis_tvalid) begin
                        r_state    <= c_S_PAYLOAD;
                        r_data     <= s_axis_tdata;
                        r_last     <= s_axis_tlast;
                        r_user     <= s_axis_tuser;
                        r_byte_cnt <= (r_state == c_S_SFD) ? 16'd1 : w_byte_cnt_inc;
                        mii_txd    <= s_axis_tdata[3:0];
                        r_crc      <= crc_nibble(r_crc, s_axis_tdata[3:0]);
                        r_phase    <= 1'b0;
                    end else begin
                        // Source starved at a byte slot: flag one error nibble, then discard.
                        r_state         <= c_S_DROP;
                        error_underflow <= 1'b1;
                        mii_tx_er       <= 1'b1;
                        mii_txd         <= 4'h0;
                        s_axis_tready   <= 1'b1;
                    end
                end

                c_S_PAD: begin
                    if (!r_phase) begin
                        mii_txd <= 4'h0;
                        r_crc   <= crc_nibble(r_crc, 4'h0);
                        r_phase <= 1'b1;
                    end else if (w_pad_needed) begin
                        mii_txd    <= 4'h0;
                        r_crc      <= crc_nibble(r_crc, 4'h0);
                        r_phase    <= 1'b0;
                        r_byte_cnt <= w_byte_cnt_inc;
                    end else begin
                        r_state  <= c_S_FCS;
                        r_cnt    <= '0;
                        mii_txd  <= w_fcs[3:0];
                        r_fcs_sr <= w_fcs >> 4;
                    end
                end

                c_S_FCS: begin
                    if (r_cnt == c_FCS_LAST) begin
                        r_state   <= c_S_IFG;
                        r_cnt     <= '0;
                        mii_tx_en <= 1'b0;
                        mii_txd   <= 4'h0;
                    end else begin
                        r_cnt    <= r_cnt + c_CNT_ONE;
                        mii_txd  <= r_fcs_sr[3:0];
                        r_fcs_sr <= r_fcs_sr >> 4;
                    end
                end

                c_S_DROP: begin
                    mii_tx_en <= 1'b0;
                    mii_txd   <= 4'h0;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        r_state <= c_S_IFG;
                        r_cnt   <= '0;
                    end else begin
                        s_axis_tready <= 1'b1;
                    end
                end

                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mii_tx_framer.md
Name: mii_tx_framer

Overview:
- Transmit-side MII framer for the 100BASE-T Ethernet path; the counterpart of the MII receive path in the core.
- Accepts one Ethernet frame per AXI-stream packet, byte-wide, with no preamble and no FCS.
- Drives the MII TX pins one nibble per clock: 7-byte preamble, SFD, payload, zero padding to the minimum frame size, CRC32 FCS and inter-frame gap.
- Sits in the phy_tx_clk domain, between the TX FIFO and phy_txd/phy_tx_en.

Parameters:
- ENABLE_PADDING, 1, pad payload with 0x00 up to MIN_FRAME_LENGTH-4 bytes.
- MIN_FRAME_LENGTH, 64, minimum frame size in bytes, FCS included.
- IFG_BYTES, 12, inter-frame gap in bytes; idle time is IFG_BYTES*2 clocks.

Ports:
- clk  input  1  MII TX clock, 25 MHz, one nibble per cycle.
- rst  input  1  reset, synchronous, active-high.
- s_axis_tdata  input  8  frame byte.
- s_axis_tvalid  input  1  byte valid.
- s_axis_tready  output  1  byte accepted when tvalid and tready are both high.
- s_axis_tlast  input  1  last byte of the frame.
- s_axis_tuser  input  1  bad frame; when set with tlast, the FCS is sent inverted.
- mii_txd  output  4  TX nibble.
- mii_tx_en  output  1  TX enable.
- mii_tx_er  output  1  TX error.
- start_packet  output  1  one-cycle pulse on the SFD cycle.
- error_underflow  output  1  one-cycle pulse when input starves mid-frame.

Behaviour:
- Reset: all outputs 0 (mii_txd=0, mii_tx_en=0, mii_tx_er=0, s_axis_tready=0, pulses 0). FSM goes to IDLE, CRC=0xFFFFFFFF. Reset mid-frame drops tx_en on the next cycle; no FCS is sent.
- All outputs are registered.
- FSM states: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG, DROP.
- IDLE: tready=0. If tvalid=1 in cycle N, tx_en=1 from cycle N+1. No byte is consumed in IDLE.
- PREAMBLE: 15 nibbles of 0x5, cycles N+1..N+15.
- SFD: nibble 0xD at cycle N+16. start_packet=1 and tready=1 in this cycle, so byte 0 is captured here.
- PAYLOAD: each captured byte is sent low nibble first, then high nibble.
  - tready=1 only in the high-nibble cycle, and only if the current byte is not tlast. This gives a back-to-back byte every 2 cycles.
  - Byte counter saturates at 0xFFFF.
- Underflow: tready=1 but tvalid=0 in PAYLOAD.
  - error_underflow pulses.
  - mii_tx_er=1 for the next nibble; tx_en stays 1 for that nibble, then drops.
  - Enter DROP: tready=1, discard bytes until tvalid&tlast, then go to IFG. No FCS is sent.
- After the tlast byte is sent:
  - If ENABLE_PADDING=1 and bytes sent < MIN_FRAME_LENGTH-4: go to PAD, emitting 0x0 nibbles up to MIN_FRAME_LENGTH-4 bytes (CRC includes the pad).
  - Otherwise go to FCS.
- CRC32: Ethernet polynomial, reflected form 0xEDB88320, init 0xFFFFFFFF, updated per nibble LSB-first over payload and pad only. Preamble and SFD are excluded.
- FCS: ~CRC sent as 8 nibbles, least significant nibble first. If tuser=1 was captured with tlast, send CRC uninverted, i.e. a deliberately bad FCS.
- IFG: tx_en=0, txd=0, tready=0 for IFG_BYTES*2 cycles, then IDLE. A tvalid held during IFG starts the next frame on the cycle IDLE is entered.
- Single-byte frame (tlast on byte 0): tready stays 0 after SFD; padding or FCS follows directly.
- tdata/tuser are sampled only on handshake. tlast with a simultaneous underflow cannot occur, since underflow requires tvalid=0.

Test Plan:
- ENABLE_PADDING=0; send "123456789" (0x31..0x39), tlast on 0x39 -> preamble 15x5, SFD D, data nibbles 1,3,2,3,...,9,3, FCS 6,2,9,3,4,F,B,C. tx_en high for 42 cycles, then 24 cycles low.
- Default params; 1-byte frame 0x00 -> 59 pad bytes of 0x00 sent, tx_en high 16+120+8=144 cycles. FCS equals the reference CRC of 60 zero bytes.
- 100-byte frame, tuser=1 on tlast -> no padding. FCS nibbles are the bitwise inverse of the good-frame FCS for the same data.
- tvalid dropped at byte 20 of a 100-byte frame -> error_underflow pulses once. tx_er=1 on one nibble, tx_en falls after it. Remaining bytes are drained until tlast, then 24 idle cycles.
- Two frames back-to-back, tvalid held high -> exactly 24 cycles with tx_en=0 between the last FCS nibble and the next preamble. start_packet pulses twice.
- rst asserted mid-PAYLOAD -> next cycle tx_en=0, tready=0. A new frame after reset starts with a full preamble and a correct FCS.
